// File: rtl/crc8_pkg.sv
// Shared CRC8/Maxim definitions: seed, check value, reflected polynomial,
// the frame appender state type and the single-byte CRC update.
package crc8_pkg;

    localparam logic [7:0] CRC8_MAXIM_INIT      = 8'h00;
    localparam logic [7:0] CRC8_MAXIM_CHECK     = 8'hA1;
    localparam logic [7:0] CRC8_MAXIM_POLY_REFL = 8'h8C;

    typedef enum logic {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_e;

    // Reflected CRC8/Maxim update of one byte, LSB first, xorout 0.
    function automatic logic [7:0] crc8_maxim_step(input logic [7:0] crc,
                                                   input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC8_MAXIM_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_maxim.sv
// Combinational CRC8/Maxim byte update: folds one data byte into the
// running CRC value.
module crc8_maxim
    import crc8_pkg::*;
(
    input  logic [7:0] last_crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] next_crc_o
);

    assign next_crc_o = crc8_maxim_step(last_crc_i, data_i);

endmodule

// File: rtl/crc8_frame_appender.sv
// Byte-stream CRC8/Maxim appender: forwards each payload byte through one
// output register and inserts the frame CRC as an extra beat after s_last.
module crc8_frame_appender
    import crc8_pkg::*;
#(
    parameter logic [7:0]  INIT_VALUE = CRC8_MAXIM_INIT,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 frame_done,
    output logic [7:0]           last_crc,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    state_e               state_q, state_d;
    logic [7:0]           crc_q, crc_d;
    logic [7:0]           crc_next;
    logic [7:0]           m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic                 frame_done_q, frame_done_d;
    logic [7:0]           last_crc_q, last_crc_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

    logic slot_free;
    logic accept;
    logic crc_xfer;

    // The output register may be refilled whenever it is empty or being drained.
    assign slot_free = !m_valid_q || m_ready;
    assign s_ready   = (state_q == PASS) && slot_free;
    assign accept    = s_valid && s_ready;
    assign crc_xfer  = m_valid_q && m_ready && m_last_q;

    crc8_maxim u_crc8_maxim (
        .last_crc_i (crc_q),
        .data_i     (s_data),
        .next_crc_o (crc_next)
    );

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        last_crc_d   = last_crc_q;
        frame_done_d = crc_xfer;
        frame_cnt_d  = crc_xfer ? frame_cnt_q + CNT_WIDTH'(1) : frame_cnt_q;

        case (state_q)
            PASS: begin
                if (accept) begin
                    m_data_d  = s_data;
                    m_last_d  = 1'b0;
                    m_valid_d = 1'b1;
                    crc_d     = crc_next;
                    if (s_last) begin
                        state_d = APPEND;
                    end
                end else if (slot_free) begin
                    m_valid_d = 1'b0;
                end
            end
            APPEND: begin
                // The CRC beat reseeds the CRC so the next frame starts clean.
                if (slot_free) begin
                    m_data_d   = crc_q;
                    m_last_d   = 1'b1;
                    m_valid_d  = 1'b1;
                    last_crc_d = crc_q;
                    crc_d      = INIT_VALUE;
                    state_d    = PASS;
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PASS;
            crc_q        <= INIT_VALUE;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            last_crc_q   <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            last_crc_q   <= last_crc_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;
    assign last_crc   = last_crc_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_crc8_frame_appender.sv
// Bench for crc8_frame_appender: scenario tasks drive frames and compare the
// observed output stream against a bit-serial CRC8/Maxim reference model.
module tb_crc8_frame_appender;
    import crc8_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        m_ready;

    logic        s_ready, m_valid, m_last, frame_done;
    logic [7:0]  m_data, last_crc;
    logic [15:0] frame_cnt;

    logic        s_ready_w, m_valid_w, m_last_w, frame_done_w;
    logic [7:0]  m_data_w, last_crc_w;
    logic [1:0]  frame_cnt_w;

    int checks = 0;
    int errors = 0;

    logic [8:0]  expQ[$];
    logic [8:0]  obsQ[$];
    logic [8:0]  obsWQ[$];
    logic [15:0] cntQ[$];
    logic [1:0]  cntWQ[$];
    int stallViol = 0;
    int doneViol = 0;
    int doneViolW = 0;
    int notReady = 0;
    int notReadyW = 0;
    int readyPct = 100;
    int bubblePct = 0;
    int modelCnt = 0;
    logic [7:0] modelLastCrc = 8'h00;

    crc8_frame_appender #(.INIT_VALUE(8'h00), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .frame_done(frame_done), .last_crc(last_crc), .frame_cnt(frame_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used for wrap behaviour.
    crc8_frame_appender #(.INIT_VALUE(8'h00), .CNT_WIDTH(2)) dutW (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_w),
        .m_data(m_data_w), .m_valid(m_valid_w), .m_last(m_last_w), .m_ready(m_ready),
        .frame_done(frame_done_w), .last_crc(last_crc_w), .frame_cnt(frame_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] refCrc(input byte_q_t bytes);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        foreach (bytes[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb  = crc[0] ^ bytes[k][b];
                crc = crc >> 1;
                if (fb) crc = crc ^ 8'h8C;
            end
        end
        return crc;
    endfunction

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(0, 99) < readyPct);
        end
    end

    // Observes transfers at the falling edge, when everything is settled.
    initial begin
        logic prevHold, prevLast, pendDone, pendDoneW;
        logic [7:0] prevData;
        prevHold = 1'b0; prevLast = 1'b0; prevData = 8'h00;
        pendDone = 1'b0; pendDoneW = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevHold  = 1'b0;
                pendDone  = 1'b0;
                pendDoneW = 1'b0;
            end else begin
                if (prevHold && !(m_valid === 1'b1 && m_data === prevData && m_last === prevLast))
                    stallViol++;
                if (frame_done !== pendDone) doneViol++;
                if (frame_done_w !== pendDoneW) doneViolW++;
                if (frame_done) cntQ.push_back(frame_cnt);
                if (frame_done_w) cntWQ.push_back(frame_cnt_w);
                if (m_valid && m_ready) obsQ.push_back({m_last, m_data});
                if (m_valid_w && m_ready) obsWQ.push_back({m_last_w, m_data_w});
                if (!s_ready) notReady++;
                if (!s_ready_w) notReadyW++;
                pendDone  = m_valid && m_ready && m_last;
                pendDoneW = m_valid_w && m_ready && m_last_w;
                prevHold  = m_valid && !m_ready;
                prevData  = m_data;
                prevLast  = m_last;
            end
        end
    end

    task automatic clearObs();
        obsQ.delete(); obsWQ.delete(); expQ.delete();
        cntQ.delete(); cntWQ.delete();
        stallViol = 0; doneViol = 0; doneViolW = 0;
        notReady = 0; notReadyW = 0;
    endtask

    task automatic doReset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearObs();
        modelCnt = 0;
        modelLastCrc = 8'h00;
    endtask

    // Sends a frame byte by byte with optional bubbles; records expected output.
    task automatic applyStimulus(input byte_q_t bytes, input bit withLast);
        int idx = 0;
        int guard = 0;
        logic acc;
        while (idx < bytes.size()) begin
            s_valid = ($urandom_range(0, 99) >= bubblePct);
            s_data  = bytes[idx];
            s_last  = withLast && (idx == bytes.size() - 1);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                guard = 0;
            end else begin
                guard++;
            end
            if (guard > 200) begin
                checks++; errors++;
                $display("[TB] FAIL accept_timeout: byte %0d not accepted, required acceptance within 200 cycles", idx);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (withLast) begin
            foreach (bytes[k]) expQ.push_back({1'b0, bytes[k]});
            modelLastCrc = refCrc(bytes);
            expQ.push_back({1'b1, modelLastCrc});
            modelCnt++;
        end
    endtask

    task automatic waitDrain(output bit drained);
        int guard = 0;
        while (obsQ.size() < expQ.size() && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        drained = (obsQ.size() >= expQ.size());
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_m_data: got %h expected 00", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last: got %b expected 0", m_last); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (last_crc !== 8'h00) begin errors++; $display("[TB] FAIL reset_last_crc: got %h expected 00", last_crc); end
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready); end
        rst = 1'b0;
        clearObs();
    endtask

    task automatic test_check_string();
        byte_q_t frame;
        bit drained;
        int startCnt;
        readyPct = 100; bubblePct = 0;
        @(posedge clk); #1;
        clearObs();
        startCnt = modelCnt;
        for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
        applyStimulus(frame, 1'b1);
        waitDrain(drained);
        checks++; if (!drained) begin errors++; $display("[TB] FAIL check_drain: got %0d beats expected %0d", obsQ.size(), expQ.size()); end
        checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL check_len: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++; if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL check_beat%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
        end
        checks++; if (obsQ.size() == 0 || obsQ[obsQ.size()-1] !== {1'b1, CRC8_MAXIM_CHECK}) begin errors++; $display("[TB] FAIL check_crc_beat: expected last beat %h", {1'b1, CRC8_MAXIM_CHECK}); end
        checks++; if (last_crc !== CRC8_MAXIM_CHECK) begin errors++; $display("[TB] FAIL check_last_crc: got %h expected %h", last_crc, CRC8_MAXIM_CHECK); end
        checks++; if (frame_cnt !== 16'(modelCnt)) begin errors++; $display("[TB] FAIL check_frame_cnt: got %0d expected %0d", frame_cnt, modelCnt); end
        checks++; if (cntQ.size() !== 1) begin errors++; $display("[TB] FAIL check_done_pulses: got %0d expected 1", cntQ.size()); end
        else begin
            checks++; if (cntQ[0] !== 16'(startCnt + 1)) begin errors++; $display("[TB] FAIL check_done_cnt: got %0d expected %0d", cntQ[0], startCnt + 1); end
        end
        checks++; if (doneViol !== 0) begin errors++; $display("[TB] FAIL check_done_timing: got %0d bad cycles expected 0", doneViol); end
    endtask

    task automatic test_back_to_back();
        byte_q_t f1, f2;
        bit drained;
        readyPct = 100; bubblePct = 0;
        @(posedge clk); #1;
        clearObs();
        f1.push_back(8'h01);
        f2.push_back(8'h01); f2.push_back(8'h02);
        applyStimulus(f1, 1'b1);
        applyStimulus(f2, 1'b1);
        waitDrain(drained);
        checks++; if (!drained || obsQ.size() !== 5) begin errors++; $display("[TB] FAIL b2b_len: got %0d expected 5", obsQ.size()); end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++; if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL b2b_beat%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
        end
        checks++; if (obsQ.size() < 5 || obsQ[1] !== 9'h15E || obsQ[4] !== 9'h178) begin errors++; $display("[TB] FAIL b2b_crc_beats: expected 15e at beat1 and 178 at beat4"); end
        checks++; if (notReady !== 2) begin errors++; $display("[TB] FAIL b2b_s_ready_low: got %0d cycles expected 2", notReady); end
        checks++; if (cntQ.size() !== 2) begin errors++; $display("[TB] FAIL b2b_done_pulses: got %0d expected 2", cntQ.size()); end
        checks++; if (frame_cnt !== 16'(modelCnt)) begin errors++; $display("[TB] FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, modelCnt); end
        checks++; if (last_crc !== 8'h78) begin errors++; $display("[TB] FAIL b2b_last_crc: got %h expected 78", last_crc); end
    endtask

    task automatic test_backpressure();
        byte_q_t frame;
        bit drained;
        readyPct = 50; bubblePct = 0;
        @(posedge clk); #1;
        clearObs();
        frame.push_back(8'h01); frame.push_back(8'h02);
        for (int r = 0; r < 6; r++) applyStimulus(frame, 1'b1);
        waitDrain(drained);
        checks++; if (!drained || obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL bp_len: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++; if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
        end
        checks++; if (stallViol !== 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", stallViol); end
        checks++; if (doneViol !== 0) begin errors++; $display("[TB] FAIL bp_done_timing: got %0d bad cycles expected 0", doneViol); end
        checks++; if (last_crc !== 8'h78) begin errors++; $display("[TB] FAIL bp_last_crc: got %h expected 78", last_crc); end
    endtask

    task automatic test_random_frames();
        byte_q_t frame;
        bit drained;
        int startCnt;
        readyPct = 65; bubblePct = 25;
        @(posedge clk); #1;
        clearObs();
        startCnt = modelCnt;
        for (int f = 0; f < 12; f++) begin
            frame.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) frame.push_back(8'($urandom_range(0, 255)));
            applyStimulus(frame, 1'b1);
        end
        waitDrain(drained);
        checks++; if (!drained || obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL rnd_len: got %0d expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++; if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL rnd_beat%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
        end
        for (int i = 0; i < cntQ.size(); i++) begin
            checks++; if (cntQ[i] !== 16'(startCnt + i + 1)) begin errors++; $display("[TB] FAIL rnd_cnt%0d: got %0d expected %0d", i, cntQ[i], startCnt + i + 1); end
        end
        checks++; if (cntQ.size() !== 12) begin errors++; $display("[TB] FAIL rnd_done_pulses: got %0d expected 12", cntQ.size()); end
        checks++; if (stallViol !== 0) begin errors++; $display("[TB] FAIL rnd_hold: got %0d unstable cycles expected 0", stallViol); end
        checks++; if (last_crc !== modelLastCrc) begin errors++; $display("[TB] FAIL rnd_last_crc: got %h expected %h", last_crc, modelLastCrc); end
        readyPct = 100; bubblePct = 0;
    endtask

    task automatic test_reset_midframe();
        byte_q_t part, frame;
        bit drained;
        readyPct = 100; bubblePct = 0;
        @(posedge clk); #1;
        part.push_back(8'h31); part.push_back(8'h32); part.push_back(8'h33);
        applyStimulus(part, 1'b0);
        doReset();
        checks++; if (frame_cnt !== 16'h0000 || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got cnt %0d valid %b expected 0 0", frame_cnt, m_valid); end
        frame.push_back(8'h01);
        applyStimulus(frame, 1'b1);
        waitDrain(drained);
        checks++; if (!drained || obsQ.size() !== 2) begin errors++; $display("[TB] FAIL mid_len: got %0d expected 2", obsQ.size()); end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++; if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL mid_beat%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
        end
        checks++; if (last_crc !== 8'h5E) begin errors++; $display("[TB] FAIL mid_last_crc: got %h expected 5e", last_crc); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL mid_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_counter_wrap();
        byte_q_t frame;
        bit drained;
        readyPct = 100; bubblePct = 0;
        doReset();
        @(posedge clk); #1;
        frame.push_back(8'h00);
        for (int f = 0; f < 5; f++) applyStimulus(frame, 1'b1);
        waitDrain(drained);
        checks++; if (!drained || obsWQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL wrap_len: got %0d expected %0d", obsWQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < obsWQ.size(); i++) begin
            checks++; if (obsWQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL wrap_beat%0d: got %h expected %h", i, obsWQ[i], expQ[i]); end
        end
        checks++; if (cntWQ.size() !== 5) begin errors++; $display("[TB] FAIL wrap_pulses: got %0d expected 5", cntWQ.size()); end
        for (int i = 0; i < cntWQ.size(); i++) begin
            checks++; if (cntWQ[i] !== 2'((i + 1) % 4)) begin errors++; $display("[TB] FAIL wrap_cnt%0d: got %0d expected %0d", i, cntWQ[i], (i + 1) % 4); end
        end
        checks++; if (frame_cnt !== 16'd5) begin errors++; $display("[TB] FAIL wrap_wide_cnt: got %0d expected 5", frame_cnt); end
        checks++; if (last_crc_w !== 8'h00) begin errors++; $display("[TB] FAIL wrap_last_crc: got %h expected 00", last_crc_w); end
        checks++; if (notReadyW !== 5) begin errors++; $display("[TB] FAIL wrap_s_ready_low: got %0d cycles expected 5", notReadyW); end
        checks++; if (doneViolW !== 0) begin errors++; $display("[TB] FAIL wrap_done_timing: got %0d bad cycles expected 0", doneViolW); end
    endtask

    task automatic test_bubbles();
        byte_q_t frame;
        bit drained;
        readyPct = 100; bubblePct = 40;
        @(posedge clk); #1;
        clearObs();
        for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
        applyStimulus(frame, 1'b1);
        waitDrain(drained);
        checks++; if (!drained || obsQ.size() !== 10) begin errors++; $display("[TB] FAIL bub_len: got %0d expected 10", obsQ.size()); end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++; if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL bub_beat%0d: got %h expected %h", i, obsQ[i], expQ[i]); end
        end
        checks++; if (last_crc !== CRC8_MAXIM_CHECK) begin errors++; $display("[TB] FAIL bub_last_crc: got %h expected %h", last_crc, CRC8_MAXIM_CHECK); end
        bubblePct = 0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        test_reset();
        test_check_string();
        test_back_to_back();
        test_backpressure();
        test_random_frames();
        test_reset_midframe();
        test_counter_wrap();
        test_bubbles();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at 2000000 time units, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/crc8_frame_appender.md
Name: crc8_frame_appender

Overview:
- Streaming controller that sequences the crc8_maxim lookup table across byte frames and appends the CRC byte after each frame's last byte.
- Sits on the TX side of the high-speed stream link, between the packet source and the serializer.
- Uses a valid/ready byte stream on both sides.
- Keeps a running CRC, a frame counter and a per-frame done pulse for link statistics.

Parameters:
- INIT_VALUE, 8'h00: CRC seed loaded at reset and at the start of every frame. CRC8/Maxim: reflected, xorout 0.
- CNT_WIDTH, 16: width of the frame counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- s_data  input  8  payload byte
- s_valid  input  1  s_data valid
- s_last  input  1  s_data is the final payload byte of the frame
- s_ready  output  1  block accepts s_data this cycle
- m_data  output  8  output byte (payload or CRC)
- m_valid  output  1  m_data valid
- m_last  output  1  m_data is the appended CRC byte (end of frame)
- m_ready  input  1  downstream accepts m_data
- frame_done  output  1  one-cycle pulse when the CRC byte is transferred
- last_crc  output  8  CRC of the most recently completed frame
- frame_cnt  output  CNT_WIDTH  number of completed frames, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=PASS, crc_reg=INIT_VALUE
  - m_valid=0, m_data=0, m_last=0
  - frame_done=0, last_crc=0, frame_cnt=0
- Reset has priority over every other event. Reset mid-frame discards the partial frame and any pending CRC byte; no CRC is emitted for it.
- Output stage:
  - Single register stage. slot_free = !m_valid || m_ready.
  - m_data, m_last and m_valid are stable while m_valid=1 and m_ready=0 (AXI-style hold).
- s_ready = (state==PASS) && slot_free. It is combinational from m_ready; there is no combinational path from s_valid.
- State PASS, on an accept (s_valid && s_ready):
  - m_data<=s_data, m_last<=0, m_valid<=1.
  - crc_reg<=crc8_maxim(crc_reg, s_data).
  - If s_last=1, go to APPEND. Latency is 1 cycle, input to output.
- State PASS, when slot_free and there is no accept: m_valid<=0.
- State APPEND:
  - s_ready=0.
  - When slot_free: m_data<=crc_reg, m_last<=1, m_valid<=1, last_crc<=crc_reg, crc_reg<=INIT_VALUE, state<=PASS.
  - Otherwise hold.
- frame_done=1 for exactly the cycle after an m_valid && m_ready && m_last transfer. frame_cnt increments on that same edge.
- Throughput:
  - A frame of N payload bytes occupies N+1 output beats.
  - Back-to-back frames under continuous m_ready lose exactly one input cycle per frame (the APPEND cycle).
  - Zero-length frames cannot occur; s_last always travels with a byte.
- Boundary conditions:
  - A 1-byte frame with s_last goes directly PASS->APPEND.
  - The CRC byte can transfer in the same cycle the next frame's first byte is accepted into the freed slot: APPEND moves to PASS at that edge, and the next accept is possible the following cycle.
  - frame_cnt wraps from all-ones to 0 silently.
  - s_valid with s_ready=0 has no effect; the upstream source must hold its data.

Decomposition:
- Shared package crc8_pkg holds:
  - CRC8_MAXIM_INIT (8'h00)
  - CRC8_MAXIM_CHECK (8'hA1, the CRC of ASCII "123456789")
  - state enum PASS/APPEND
- One sub-module instance: crc8_maxim, the existing combinational LUT (last_crc=crc_reg, data=s_data). No other sub-modules.

Test Plan:
- Check string: send 31 32 33 34 35 36 37 38 39 (s_last on 39), m_ready=1 -> output 31..39, then A1 with m_last=1. last_crc=A1, frame_cnt=1, one frame_done pulse.
- Short frames back-to-back:
  - {01} then {01,02}, continuous valid/ready -> 01,5E(last),01,02,78(last).
  - s_ready low exactly one cycle after each s_last. frame_cnt=2.
- Backpressure: frame {01,02} with m_ready toggled randomly (including low during the CRC beat) -> m_data/m_last stable while stalled, final stream 01,02,78. No byte lost or duplicated.
- Reset mid-frame: send 31 32 33, assert rst for 1 cycle, then send frame {01} -> only 01,5E(last) appear after reset. frame_cnt=1, crc seed restored to 00.
- Counter wrap: with CNT_WIDTH=2, send 5 single-byte frames {00} -> each CRC byte is 00, and frame_cnt reads 1,2,3,0,1.
- Input bubbles: frame 31..39 with s_valid deasserted on random cycles -> output identical to the check-string case, CRC A1.
